// File: rtl/freq_gen_pkg.sv
// -----------------------------------------------------------------------------
// freq_gen_pkg
//   Shared widths and state encoding for the programmable square-wave
//   generator (freq_gen).
//   - FREQ_DATA_NBIT : width of the period / high-time fields
//   - FREQ_CNT_NBIT  : width of the pulse counter
//   - freq_gen_state_t : generator state (idle or running)
// -----------------------------------------------------------------------------
package freq_gen_pkg;

  localparam int FREQ_DATA_NBIT = 32;
  localparam int FREQ_CNT_NBIT  = 16;

  typedef enum logic [0:0] {
    FREQ_GEN_IDLE = 1'b0,
    FREQ_GEN_RUN  = 1'b1
  } freq_gen_state_t;

endpackage : freq_gen_pkg

// File: rtl/freq_gen.sv
// -----------------------------------------------------------------------------
// freq_gen
//   Programmable square-wave generator driving one IO. On start it emits
//   i_cnt pulses, each i_period clk cycles long with i_high cycles high, then
//   raises done. i_cnt = 0 runs until stop.
//
// Ports
//   clk       in  1          system clock
//   rst       in  1          asynchronous, active-high reset
//   start     in  1          1-cycle pulse: latch config, begin generation
//   stop      in  1          1-cycle pulse: abort generation
//   i_period  in  DATA_NBIT  period in clk cycles (>= 2)
//   i_high    in  DATA_NBIT  high time in clk cycles (1 .. i_period-1)
//   i_cnt     in  CNT_NBIT   number of pulses, 0 = continuous
//   o_io      out 1          generated waveform (single flop)
//   o_pcnt    out CNT_NBIT   pulses completed in current/last run
//   busy      out 1          high while generating
//   o_err     out 1          config invalid or run aborted by stop
//   done      out 1          run finished; cleared by the next start
// -----------------------------------------------------------------------------
module freq_gen
  import freq_gen_pkg::*;
#(
  parameter int   DATA_NBIT  = FREQ_DATA_NBIT,
  parameter int   CNT_NBIT   = FREQ_CNT_NBIT,
  parameter logic IDLE_LEVEL = 1'b0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 stop,
  input  logic [DATA_NBIT-1:0] i_period,
  input  logic [DATA_NBIT-1:0] i_high,
  input  logic [CNT_NBIT-1:0]  i_cnt,
  output logic                 o_io,
  output logic [CNT_NBIT-1:0]  o_pcnt,
  output logic                 busy,
  output logic                 o_err,
  output logic                 done
);

  freq_gen_state_t      state_r,  state_s;
  logic [DATA_NBIT-1:0] period_r, period_s;
  logic [DATA_NBIT-1:0] high_r,   high_s;
  logic [CNT_NBIT-1:0]  cnt_r,    cnt_s;
  logic [DATA_NBIT-1:0] ph_r,     ph_s;
  logic [CNT_NBIT-1:0]  pcnt_r,   pcnt_s;
  logic                 io_r,     io_s;
  logic                 busy_r,   busy_s;
  logic                 err_r,    err_s;
  logic                 done_r,   done_s;

  logic                 cfg_valid_s;
  logic                 ph_last_s;
  logic [DATA_NBIT-1:0] ph_next_s;
  logic [CNT_NBIT-1:0]  pcnt_inc_s;
  logic                 last_pulse_s;

  // Config check on the incoming (not yet latched) values, plus phase helpers.
  // ph_r is the phase of the level currently on o_io, so the next level is
  // derived from the next phase; this gives o_io = 1 on the cycle right after
  // start without a combinational path to the pin.
  always_comb begin
    cfg_valid_s  = (i_period >= DATA_NBIT'(2)) &&
                   (i_high != {DATA_NBIT{1'b0}}) &&
                   (i_high < i_period);
    ph_last_s    = (ph_r == (period_r - DATA_NBIT'(1)));
    ph_next_s    = ph_last_s ? {DATA_NBIT{1'b0}} : (ph_r + DATA_NBIT'(1));
    pcnt_inc_s   = pcnt_r + CNT_NBIT'(1);
    last_pulse_s = (cnt_r != {CNT_NBIT{1'b0}}) && (pcnt_inc_s == cnt_r);
  end

  // Next-state and next-output logic; start has priority over stop and over
  // the running phase logic, so a start always (re)launches a run.
  always_comb begin
    state_s  = state_r;
    period_s = period_r;
    high_s   = high_r;
    cnt_s    = cnt_r;
    ph_s     = ph_r;
    pcnt_s   = pcnt_r;
    io_s     = io_r;
    busy_s   = busy_r;
    err_s    = err_r;
    done_s   = done_r;

    if (start) begin
      period_s = i_period;
      high_s   = i_high;
      cnt_s    = i_cnt;
      ph_s     = {DATA_NBIT{1'b0}};
      pcnt_s   = {CNT_NBIT{1'b0}};
      if (cfg_valid_s) begin
        // Phase 0 is always high because high >= 1.
        state_s = FREQ_GEN_RUN;
        io_s    = 1'b1;
        busy_s  = 1'b1;
        err_s   = 1'b0;
        done_s  = 1'b0;
      end else begin
        state_s = FREQ_GEN_IDLE;
        io_s    = IDLE_LEVEL;
        busy_s  = 1'b0;
        err_s   = 1'b1;
        done_s  = 1'b1;
      end
    end else begin
      case (state_r)
        FREQ_GEN_RUN: begin
          if (stop) begin
            // Abort: completed-pulse count is kept as is.
            state_s = FREQ_GEN_IDLE;
            io_s    = IDLE_LEVEL;
            busy_s  = 1'b0;
            err_s   = 1'b1;
            done_s  = 1'b1;
          end else begin
            ph_s = ph_next_s;
            io_s = (ph_next_s < high_r);
            if (ph_last_s) begin
              pcnt_s = pcnt_inc_s;
              if (last_pulse_s) begin
                state_s = FREQ_GEN_IDLE;
                io_s    = IDLE_LEVEL;
                busy_s  = 1'b0;
                done_s  = 1'b1;
              end else begin
                state_s = FREQ_GEN_RUN;
              end
            end else begin
              state_s = FREQ_GEN_RUN;
            end
          end
        end
        FREQ_GEN_IDLE: begin
          io_s   = IDLE_LEVEL;
          busy_s = 1'b0;
        end
        default: begin
          state_s = FREQ_GEN_IDLE;
          io_s    = IDLE_LEVEL;
          busy_s  = 1'b0;
        end
      endcase
    end
  end

  // State and output registers with asynchronous reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r  <= FREQ_GEN_IDLE;
      period_r <= {DATA_NBIT{1'b0}};
      high_r   <= {DATA_NBIT{1'b0}};
      cnt_r    <= {CNT_NBIT{1'b0}};
      ph_r     <= {DATA_NBIT{1'b0}};
      pcnt_r   <= {CNT_NBIT{1'b0}};
      io_r     <= IDLE_LEVEL;
      busy_r   <= 1'b0;
      err_r    <= 1'b0;
      done_r   <= 1'b0;
    end else begin
      state_r  <= state_s;
      period_r <= period_s;
      high_r   <= high_s;
      cnt_r    <= cnt_s;
      ph_r     <= ph_s;
      pcnt_r   <= pcnt_s;
      io_r     <= io_s;
      busy_r   <= busy_s;
      err_r    <= err_s;
      done_r   <= done_s;
    end
  end

  assign o_io   = io_r;
  assign o_pcnt = pcnt_r;
  assign busy   = busy_r;
  assign o_err  = err_r;
  assign done   = done_r;

endmodule : freq_gen
